// File: rtl/ysyx_22040237_exu_muldiv.sv
// Iterative M-extension multiply/divide unit. Multiplies and divides operand
// magnitudes one bit per cycle, then applies the sign; word ops run 32 steps.
module ysyx_22040237_exu_muldiv #(
  parameter int XLEN  = 64,
  parameter int HAS_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic            op_err,
  output logic [1:0]      state_dbg
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both
  // high; the producer holds valid and its data stable until that edge.

  localparam bit W_EN = (XLEN != 32) && (HAS_W != 0);
  localparam int CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] LO32   = XLEN'(64'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_W  = XLEN'(64'h8000_0000);
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_mul_q, op_mul_d, op_w_q, op_w_d;
  logic                op_high_q, op_high_d, op_rem_q, op_rem_d;
  logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     part_q, part_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic                op_err_q, op_err_d;

  logic dec_mul, dec_div, dec_w, dec_s1, dec_s2, dec_high, dec_rem, dec_illegal;
  logic [XLEN-1:0] wmask, v1, v2, mag1, mag2;
  logic sgn1, sgn2, div_zero, div_ovf;

  always_comb begin
    dec_mul = 1'b0; dec_div = 1'b0; dec_w = 1'b0; dec_s1 = 1'b0;
    dec_s2 = 1'b0; dec_high = 1'b0; dec_rem = 1'b0; dec_illegal = 1'b0;
    case (op)
      4'd0:  begin dec_mul = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd1:  begin dec_mul = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; dec_high = 1'b1; end
      4'd2:  begin dec_mul = 1'b1; dec_s1 = 1'b1; dec_high = 1'b1; end
      4'd3:  begin dec_mul = 1'b1; dec_high = 1'b1; end
      4'd4:  begin dec_div = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd5:  begin dec_div = 1'b1; end
      4'd6:  begin dec_div = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; dec_rem = 1'b1; end
      4'd7:  begin dec_div = 1'b1; dec_rem = 1'b1; end
      4'd8:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      4'd9:  begin dec_div = 1'b1; dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd10: begin dec_div = 1'b1; dec_w = 1'b1; end
      4'd11: begin dec_div = 1'b1; dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; dec_rem = 1'b1; end
      4'd12: begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_w && !W_EN) dec_illegal = 1'b1;

    wmask    = dec_w ? LO32 : '1;
    v1       = op1 & wmask;
    v2       = op2 & wmask;
    sgn1     = dec_s1 && (dec_w ? op1[31] : op1[XLEN-1]);
    sgn2     = dec_s2 && (dec_w ? op2[31] : op2[XLEN-1]);
    mag1     = sgn1 ? ((-v1) & wmask) : v1;
    mag2     = sgn2 ? ((-v2) & wmask) : v2;
    div_zero = dec_div && (v2 == '0);
    div_ovf  = dec_div && dec_s1 && (v1 == (dec_w ? MIN_W : MIN_X)) && (v2 == wmask);
  end

  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN:0]     sh;
  logic              take;
  logic [XLEN-1:0]   part_nx, dvd_nx, quo, remv, res_raw, result;
  logic [CW-1:0]     last_cnt;

  always_comb begin
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Restoring step: bring down the next dividend bit, keep the difference if it fits.
    sh       = {part_q, dvd_q[XLEN-1]};
    take     = (sh >= {1'b0, dvs_q});
    part_nx  = take ? XLEN'(sh - {1'b0, dvs_q}) : sh[XLEN-1:0];
    dvd_nx   = {dvd_q[XLEN-2:0], take};
    prod     = neg_res_q ? -acc_nx : acc_nx;
    quo      = neg_res_q ? -dvd_nx : dvd_nx;
    remv     = neg_rem_q ? -part_nx : part_nx;
    if (op_mul_q) res_raw = op_high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else          res_raw = op_rem_q ? remv : quo;
    result   = op_w_q ? sext32(res_raw[31:0]) : res_raw;
    last_cnt = op_w_q ? CW'(31) : CW'(XLEN-1);
  end

  always_comb begin
    state_d   = state_q;   cnt_d     = cnt_q;
    op_mul_d  = op_mul_q;  op_w_d    = op_w_q;
    op_high_d = op_high_q; op_rem_d  = op_rem_q;
    neg_res_d = neg_res_q; neg_rem_d = neg_rem_q;
    acc_d     = acc_q;     mcand_d   = mcand_q;   mplier_d = mplier_q;
    part_d    = part_q;    dvd_d     = dvd_q;     dvs_d    = dvs_q;
    rd_data_d = rd_data_q; op_err_d  = op_err_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_mul_d  = dec_mul;
            op_w_d    = dec_w;
            op_high_d = dec_high;
            op_rem_d  = dec_rem;
            neg_res_d = sgn1 ^ sgn2;
            neg_rem_d = sgn1;
            op_err_d  = 1'b0;
            if (dec_illegal) begin
              state_d   = S_DONE;
              rd_data_d = '0;
              op_err_d  = 1'b1;
            end else if (div_zero) begin
              state_d   = S_DONE;
              rd_data_d = dec_rem ? (dec_w ? sext32(op1[31:0]) : op1) : '1;
            end else if (div_ovf) begin
              state_d   = S_DONE;
              rd_data_d = dec_rem ? '0 : (dec_w ? sext32(op1[31:0]) : op1);
            end else begin
              state_d  = S_BUSY;
              cnt_d    = '0;
              acc_d    = '0;
              mcand_d  = {{XLEN{1'b0}}, mag1};
              mplier_d = mag2;
              part_d   = '0;
              // Word divides start from bit 31, so park the dividend at the top.
              dvd_d    = dec_w ? (mag1 << 32) : mag1;
              dvs_d    = mag2;
            end
          end
        end
        S_BUSY: begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          part_d   = part_nx;
          dvd_d    = dvd_nx;
          if (cnt_q == last_cnt) begin
            state_d   = S_DONE;
            rd_data_d = result;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;  cnt_q     <= '0;
      op_mul_q  <= 1'b0;    op_w_q    <= 1'b0;
      op_high_q <= 1'b0;    op_rem_q  <= 1'b0;
      neg_res_q <= 1'b0;    neg_rem_q <= 1'b0;
      acc_q     <= '0;      mcand_q   <= '0;     mplier_q <= '0;
      part_q    <= '0;      dvd_q     <= '0;     dvs_q    <= '0;
      rd_data_q <= '0;      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;   cnt_q     <= cnt_d;
      op_mul_q  <= op_mul_d;  op_w_q    <= op_w_d;
      op_high_q <= op_high_d; op_rem_q  <= op_rem_d;
      neg_res_q <= neg_res_d; neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;     mcand_q   <= mcand_d;   mplier_q <= mplier_d;
      part_q    <= part_d;    dvd_q     <= dvd_d;     dvs_q    <= dvs_d;
      rd_data_q <= rd_data_d; op_err_q  <= op_err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign rd_data   = rd_data_q;
  assign op_err    = op_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ysyx_22040237_exu_muldiv.sv
// Bench for the multiply/divide unit: directed vectors, randomized ops against
// an arithmetic reference model, backpressure, flush and mid-operation reset.
module tb_ysyx_22040237_exu_muldiv;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, op_err;
  logic [3:0]  op;
  logic [63:0] op1, op2, rd_data;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  int          lat_q[$];

  ysyx_22040237_exu_muldiv #(.XLEN(64), .HAS_W(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .rd_data(rd_data), .op_err(op_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Returns {op_err, rd_data}.
  function automatic logic [64:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    logic err;
    err = 1'b0; r = '0; r32 = '0; p = '0;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    case (o)
      4'd0: r = a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      4'd4: begin
        if (b == 0) r = '1;
        else if (a == MIN64 && b == '1) r = a;
        else r = sa / sb;
      end
      4'd5: begin if (b == 0) r = '1; else r = a / b; end
      4'd6: begin
        if (b == 0) r = a;
        else if (a == MIN64 && b == '1) r = '0;
        else r = sa % sb;
      end
      4'd7: begin if (b == 0) r = a; else r = a % b; end
      4'd8: begin r32 = a32 * b32; r = sx(r32); end
      4'd9: begin
        if (b32 == 0) r32 = '1;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
        else r32 = sa32 / sb32;
        r = sx(r32);
      end
      4'd10: begin if (b32 == 0) r32 = '1; else r32 = a32 / b32; r = sx(r32); end
      4'd11: begin
        if (b32 == 0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
        else r32 = sa32 % sb32;
        r = sx(r32);
      end
      4'd12: begin if (b32 == 0) r32 = a32; else r32 = a32 % b32; r = sx(r32); end
      default: err = 1'b1;
    endcase
    return {err, r};
  endfunction

  // Cycles from the acceptance edge until out_valid is first seen.
  function automatic int model_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o > 4'd12) return 1;
    if (o >= 4'd4 && o <= 4'd7) begin
      if (b == 0) return 1;
      if ((o == 4'd4 || o == 4'd6) && a == MIN64 && b == '1) return 1;
      return 65;
    end
    if (o >= 4'd9) begin
      if (b[31:0] == 0) return 1;
      if ((o == 4'd9 || o == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
      return 33;
    end
    return (o == 4'd8) ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return {32'($urandom), 32'h8000_0000};
      4: return 64'($urandom_range(0, 50));
      5: return -64'($urandom_range(1, 50));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] rd, output logic err, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); op1 = {32'($urandom), 32'($urandom)}; op2 = {32'($urandom), 32'($urandom)};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    rd = rd_data;
    err = op_err;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; op1 = '0; op2 = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err got %b exp 0", op_err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  t_op[10];
    logic [63:0] t_a[10], t_b[10], t_exp[10];
    logic        t_err[10];
    int          t_lat[10];
    logic [63:0] rd;
    logic        err;
    int          lat;
    t_op  = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd5, 4'd4, 4'd11, 4'd8, 4'd14, 4'd9};
    t_a   = '{'1, '1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, MIN64,
              64'h8000_0000, 64'h1_4000_0000, 64'd5, 64'h1234_5678_FFFF_FF9C};
    t_b   = '{64'd3, 64'd3, 64'd2, 64'd2, 64'd0, '1, 64'hFFFF_FFFF, 64'd2, 64'd6, 64'd7};
    t_exp = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, '1, '1, MIN64,
              64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF2};
    t_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_lat = '{65, 65, 65, 65, 1, 1, 1, 33, 1, 33};
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], rd, err, lat);
      checks++; if (rd !== t_exp[i]) begin errors++; $display("FAIL dir_rd[%0d] got %h exp %h", i, rd, t_exp[i]); end
      checks++; if (err !== t_err[i]) begin errors++; $display("FAIL dir_err[%0d] got %b exp %b", i, err, t_err[i]); end
      checks++; if (lat != t_lat[i]) begin errors++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, lat, t_lat[i]); end
      consume();
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [63:0] a, b, rd;
    logic        err;
    int          lat, exp_lat;
    logic [64:0] exp;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(model(o, a, b));
      lat_q.push_back(model_lat(o, a, b));
      run_op(o, a, b, rd, err, lat);
      exp = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      checks++; if (rd !== exp[63:0]) begin errors++; $display("FAIL rand_rd op=%0d a=%h b=%h got %h exp %h", o, a, b, rd, exp[63:0]); end
      checks++; if (err !== exp[64]) begin errors++; $display("FAIL rand_err op=%0d got %b exp %b", o, err, exp[64]); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_lat op=%0d got %0d exp %0d", o, lat, exp_lat); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd;
    logic        err;
    int          lat;
    run_op(4'd0, 64'd123456789, 64'd1000, rd, err, lat);
    checks++; if (rd !== 64'd123456789000) begin errors++; $display("FAIL bp_rd got %h exp %h", rd, 64'd123456789000); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (rd_data !== 64'd123456789000) begin errors++; $display("FAIL bp_hold_rd[%0d] got %h exp %h", i, rd_data, 64'd123456789000); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d] got %b exp 0", i, in_ready); end
    end
    // Offer a request in the same cycle the result is consumed.
    out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; op1 = 64'd5; op2 = 64'd5;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_after_consume got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got in_ready=%b exp 0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 65) begin errors++; $display("FAIL b2b_lat got %0d exp 65", lat); end
    checks++; if (rd_data !== 64'd25) begin errors++; $display("FAIL b2b_rd got %h exp %h", rd_data, 64'd25); end
    consume();
  endtask

  task automatic test_flush();
    logic [63:0] rd;
    logic        err;
    int          lat;
    logic        seen;
    @(negedge clk);
    in_valid = 1'b1; op = 4'd5; op1 = 64'hDEAD_BEEF_1234_5678; op2 = 64'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_busy got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got %b exp 0", seen); end
    // Flush while a result waits in DONE.
    run_op(4'd5, 64'd7, 64'd0, rd, err, lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    // Flush wins over a simultaneous request.
    in_valid = 1'b1; flush = 1'b1; op = 4'd0; op1 = 64'd2; op2 = 64'd3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_vs_accept got in_ready=%b exp 1", in_ready); end
    run_op(4'd6, 64'd100, 64'd7, rd, err, lat);
    checks++; if (rd !== 64'd2) begin errors++; $display("FAIL flush_next_rd got %h exp 2", rd); end
    checks++; if (lat != 65) begin errors++; $display("FAIL flush_next_lat got %0d exp 65", lat); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd;
    logic        err;
    int          lat;
    logic        seen;
    run_op(4'd0, 64'd3, 64'd5, rd, err, lat);
    consume();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; op1 = 64'd9; op2 = 64'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL rmid_rd_data got %h exp 0", rd_data); end
    checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL rmid_op_err got %b exp 0", op_err); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    rst = 1'b1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_held got %b exp 0", seen); end
    run_op(4'd0, 64'd6, 64'd7, rd, err, lat);
    checks++; if (rd !== 64'd42) begin errors++; $display("FAIL rmid_mul_rd got %h exp %h", rd, 64'd42); end
    checks++; if (lat != 65) begin errors++; $display("FAIL rmid_mul_lat got %0d exp 65", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_mul_err got %b exp 0", err); end
    consume();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
